// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int          WIDTH_DEF = 32;
   localparam logic [31:0] DIV0_LO   = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdu_state_t;

endpackage

// File: rtl/mdu_iter_if.sv
// Multicycle-op handshake between the EX stage (master) and the MDU (slave).
interface mdu_iter_if
   import mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic               start;
   logic [1:0]         op;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               flush;
   logic               stall;
   logic               done;
   logic [2*WIDTH-1:0] hilo;
   logic               busy;

   modport master (
      output start, op, a, b, flush,
      input  stall, done, hilo, busy
   );

   modport slave (
      input  start, op, a, b, flush,
      output stall, done, hilo, busy
   );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract divisor.
module mdu_div_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Shifted partial remainder needs WIDTH+1 bits; a set MSB of diff means borrow.
   assign shifted = {rem_in, quo_in[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor};
   assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU responder for the EX multicycle handshake.
// Define MDU_FAST_MUL_EN to compute multiplies in one cycle in FIX instead of RUN.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ITER  = WIDTH
) (
   input logic       clk,
   input logic       rst,
   mdu_iter_if.slave bus
);
   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

   mdu_state_t         state;
   logic [CNT_W-1:0]   counter;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [1:0]         opReg;
   logic               negA;
   logic               negB;
   logic               divZero;
   logic [2*WIDTH-1:0] hiloReg;

   logic               accept;
   logic               isDiv;
   logic               isSigned;
   logic               bZero;
   logic [WIDTH-1:0]   absA;
   logic [WIDTH-1:0]   absB;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH-1:0]   remNext;
   logic [WIDTH-1:0]   quoNext;
   logic [WIDTH-1:0]   fixRem;
   logic [WIDTH-1:0]   fixQuo;
   logic [2*WIDTH-1:0] fixProd;
   logic [2*WIDTH-1:0] fixResult;

   function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   assign accept   = bus.start && !bus.flush && (state == IDLE || state == DONE);
   assign isDiv    = bus.op[1];
   assign isSigned = !bus.op[0];
   assign bZero    = (bus.b == '0);
   assign absA     = absVal(bus.a, isSigned);
   assign absB     = absVal(bus.b, isSigned);

   assign bus.stall = accept || bus.busy;
   assign bus.busy  = (state == RUN) || (state == FIX);
   assign bus.done  = (state == DONE);
   assign bus.hilo  = hiloReg;

   // Multiplier sits in acc's low half and drains out of bit 0 as the product shifts in.
   assign mulSum = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                          : {1'b0, acc[2*WIDTH-1:WIDTH]};

   mdu_div_step #(.WIDTH(WIDTH)) u_divStep (
      .rem_in  (acc[2*WIDTH-1:WIDTH]),
      .quo_in  (acc[WIDTH-1:0]),
      .divisor (opnd),
      .rem_out (remNext),
      .quo_out (quoNext)
   );

   always_comb begin
      fixRem    = acc[2*WIDTH-1:WIDTH];
      fixQuo    = acc[WIDTH-1:0];
`ifdef MDU_FAST_MUL_EN
      fixProd   = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
      fixProd   = acc;
`endif
      fixResult = acc;
      if (divZero) begin
         fixResult = acc;
      end else if (opReg[1]) begin
         // Quotient sign follows the operand signs; remainder follows the dividend.
         if (!opReg[0] && (negA ^ negB)) fixQuo = -fixQuo;
         if (!opReg[0] && negA)          fixRem = -fixRem;
         fixResult = {fixRem, fixQuo};
      end else begin
         if (!opReg[0] && (negA ^ negB)) fixProd = -fixProd;
         fixResult = fixProd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         counter <= '0;
         acc     <= '0;
         opnd    <= '0;
         opReg   <= OP_MULT;
         negA    <= 1'b0;
         negB    <= 1'b0;
         divZero <= 1'b0;
         hiloReg <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (accept) begin
                  opReg   <= bus.op;
                  negA    <= isSigned && bus.a[WIDTH-1];
                  negB    <= isSigned && bus.b[WIDTH-1];
                  counter <= '0;
                  divZero <= isDiv && bZero;
                  if (isDiv) begin
                     opnd  <= absB;
                     acc   <= bZero ? {bus.a, WIDTH'(DIV0_LO)} : {{WIDTH{1'b0}}, absA};
                     state <= bZero ? FIX : RUN;
                  end else begin
                     opnd  <= absA;
                     acc   <= {{WIDTH{1'b0}}, absB};
`ifdef MDU_FAST_MUL_EN
                     state <= FIX;
`else
                     state <= RUN;
`endif
                  end
               end
            end
            RUN: begin
               if (bus.flush) begin
                  state <= IDLE;
               end else begin
                  acc     <= opReg[1] ? {remNext, quoNext} : {mulSum, acc[WIDTH-1:1]};
                  counter <= counter + 1'b1;
                  if (counter == CNT_W'(ITER - 1)) state <= FIX;
               end
            end
            FIX: begin
               if (bus.flush) begin
                  state <= IDLE;
               end else begin
                  hiloReg <= fixResult;
                  state   <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: latency, results, flush and reset.
module tb_mdu_iter;
   import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
   localparam int MulLat = 2;
`else
   localparam int MulLat = 34;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mdu_iter_if #(.WIDTH(32)) bus ();

   mdu_iter #(.WIDTH(32), .ITER(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request in the current cycle and returns in its DONE cycle.
   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int lat, input logic [63:0] expHilo,
                        input int pokeAt);
      int cyc;
      bit stallOk;
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      #1;
      chk({tag, "_stallN"}, {63'd0, bus.stall}, 64'd1);
      tick();
      bus.start = 1'b0;
      bus.op    = ~o;
      bus.a     = ~x;
      bus.b     = y + 32'd1;
      cyc       = 1;
      stallOk   = 1'b1;
      while (bus.done !== 1'b1 && cyc < 60) begin
         if (bus.stall !== 1'b1 || bus.busy !== 1'b1) stallOk = 1'b0;
         bus.start = (cyc == pokeAt);
         tick();
         bus.start = 1'b0;
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(lat));
      chk({tag, "_stallHeld"}, {63'd0, stallOk}, 64'd1);
      chk({tag, "_stallDone"}, {63'd0, bus.stall}, 64'd0);
      chk({tag, "_hilo"}, bus.hilo, expHilo);
   endtask

   initial begin
      int  cyc;
      bit  sawDone;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = OP_MULT;
      bus.a     = '0;
      bus.b     = '0;

      repeat (2) tick();
      chk("rst_hilo", bus.hilo, 64'd0);
      chk("rst_ctl", {61'd0, bus.done, bus.busy, bus.stall}, 64'd0);
      rst = 1'b1;
      tick();

      runOp("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MulLat, 64'hFFFFFFFE_00000001, 0);
      tick();
      chk("done_pulse", {62'd0, bus.done, bus.busy}, 64'd0);

      runOp("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, MulLat, 64'hFFFFFFFF_FFFFFFEB, 0);
      tick();
      runOp("mult_negneg", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFF9, MulLat, 64'h00000000_00000015, 0);
      tick();
      runOp("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 34, 64'hFFFFFFFF_FFFFFFFD, 0);
      tick();
      runOp("div_negdsr", OP_DIV, 32'd7, 32'hFFFFFFFE, 34, 64'h00000001_FFFFFFFD, 0);
      tick();
      runOp("divu", OP_DIVU, 32'd100, 32'd7, 34, 64'h00000002_0000000E, 0);
      tick();
      runOp("divu_zero", OP_DIVU, 32'd100, 32'd0, 2, 64'h00000064_FFFFFFFF, 0);
      tick();
      runOp("div_zero", OP_DIV, 32'hFFFFFFF9, 32'd0, 2, 64'hFFFFFFF9_FFFFFFFF, 0);
      tick();
      runOp("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 64'h00000000_80000000, 0);

      // Back-to-back from the DONE cycle; the second op also sees a start poke mid-RUN.
      runOp("b2b_first", OP_DIVU, 32'd100, 32'd7, 34, 64'h00000002_0000000E, 0);
      runOp("b2b_second", OP_DIVU, 32'd1000, 32'd10, 34, 64'h00000000_00000064, 5);
      tick();

      // Flush at N+10.
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 32'd55;
      bus.b     = 32'd5;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_idle", {62'd0, bus.busy, bus.stall}, 64'd0);
      sawDone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) sawDone = 1'b1;
         tick();
      end
      chk("flush_nodone", {63'd0, sawDone}, 64'd0);
      chk("flush_hilo", bus.hilo, 64'h00000000_00000064);

      // flush with start in IDLE rejects the request.
      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.op    = OP_DIVU;
      #1;
      chk("flushstart_stall", {63'd0, bus.stall}, 64'd0);
      tick();
      bus.start = 1'b0;
      bus.flush = 1'b0;
      chk("flushstart_busy", {63'd0, bus.busy}, 64'd0);

      // Asynchronous reset at N+20.
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 32'd77;
      bus.b     = 32'd3;
      tick();
      bus.start = 1'b0;
      repeat (19) tick();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_ctl", {61'd0, bus.done, bus.busy, bus.stall}, 64'd0);
      chk("arst_hilo", bus.hilo, 64'd0);
      tick();
      tick();
      rst = 1'b1;
      cyc     = 0;
      sawDone = 1'b0;
      while (cyc < 40) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone = 1'b1;
         tick();
         cyc++;
      end
      chk("arst_quiet", {63'd0, sawDone}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit. It is the responder side of the EX stage's multicycle-op handshake: EX raises a request, holds the pipeline on stall, and captures the HI/LO result when done pulses.
- Handles MULT, MULTU, DIV and DIVU with radix-2 shift-add and restoring-divide datapaths.
- Results are consumed by EX as hiloData and written to the HI/LO registers.

Parameters:
WIDTH, 32, operand width; the result is 2*WIDTH bits.
ITER, WIDTH, number of RUN iterations per operation.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; asynchronous, active-low; all state cleared while low.
start  input  1  request; sampled only in IDLE or DONE.
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
a  input  WIDTH  multiplicand / dividend (rs).
b  input  WIDTH  multiplier / divisor (rt).
flush  input  1  abort the in-flight operation (exception / branch kill).
stall  output  1  EX must hold; combinational.
done  output  1  one-cycle pulse; hilo valid.
hilo  output  2*WIDTH  {HI, LO}; held until the next accepted start.
busy  output  1  state is RUN or FIX.

Behaviour:
- States: IDLE, RUN, FIX, DONE.
- Reset: state=IDLE, counter=0, hilo=0, done=0, busy=0, stall=0.

Handshake:
- Request accepted in cycle N when start=1, flush=0 and state is IDLE or DONE.
- Operands and op are registered at the end of cycle N. Signed ops store absolute values plus sign flags.
- stall is (start & (IDLE|DONE) & !flush) | busy. It is high in cycles N..N+33.
- done=1 only in state DONE, i.e. cycle N+34; stall=0 in that cycle.
- DONE lasts one cycle, then IDLE unless a new start is accepted (back-to-back allowed).
- start in RUN or FIX is ignored.

RUN (32 cycles, N+1..N+32):
- Multiply: if multiplier LSB=1, add multiplicand to the upper half of the 64-bit accumulator; then shift right one bit, carry included.
- Divide: shift {rem,quo} left one bit; trial-subtract the divisor; on no borrow, keep the difference and set quotient bit 0.
- Counter counts 0..31; on 31 go to FIX.

FIX (cycle N+33):
- Sign correction for signed ops.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
- Register hilo = {HI=remainder|product[63:32], LO=quotient|product[31:0]}. Go to DONE.

Boundary conditions:
- Divide by zero (b==0, DIV or DIVU): skip RUN; IDLE/DONE -> FIX -> DONE. done lands at N+2 with HI=a (raw), LO=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (32-bit wrap, no trap).
- flush in RUN or FIX: next state IDLE, done never asserted, hilo unchanged.
- flush together with start in IDLE/DONE: request rejected.
- rst low mid-operation: immediate return to the reset values; no done.
- Operand changes after acceptance have no effect.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU compute the product with a single-cycle multiplier in FIX and skip RUN. done lands at N+2, stall is high in N..N+1. Divide behaviour is unchanged.
- Undefined: multiplies use the 32-iteration path, done at N+34.

Decomposition:
- mdu_pkg holds:
  - the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum typedef mdu_state_t;
  - WIDTH_DEF=32;
  - DIV0_LO=32'hFFFFFFFF.
- One sub-module, mdu_div_step: purely combinational restoring-division step (rem_in, quo_in, divisor -> rem_out, quo_out). It is instantiated once and used each RUN cycle.
- Sign fix-up and the accumulator stay in the top module.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at N -> stall high N..N+33, done at N+34, hilo=0xFFFFFFFE_00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hilo=0xFFFFFFFF_FFFFFFEB. With MDU_FAST_MUL_EN, same value with done at N+2.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100 b=7 -> LO=14, HI=2.
- DIVU a=100 b=0 -> done at N+2, HI=100, LO=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Back-to-back: start asserted in the DONE cycle of the previous op -> new op accepted, stall rises the same cycle, second done 34 cycles later. start in RUN -> ignored.
- flush at N+10 -> IDLE at N+11, stall=0, no done, hilo keeps its prior value. rst low at N+20 -> all outputs 0 asynchronously, no done.
